// File: rtl/rc522_spi_reg_ctrl.sv
// RC522 single-register SPI access controller: one 16-bit mode-0 frame per request,
// address byte {rw, addr, 0} followed by write data (or 0x00 for a read).
module rc522_spi_reg_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk_system,
  input  logic       reset_system,
  input  logic       req,
  input  logic       rw,
  input  logic [5:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  input  logic       miso,
  output logic       mosi,
  output logic       clk_spi,
  output logic       cs
);

  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST = (CLK_DIV > 1) ? DW'(CLK_DIV - 2) : '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_DONE,
    ST_GAP
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   divCnt_q;
  logic [DW-1:0]   divCnt_d;
  logic            divLast;
  logic [4:0]      bitCnt_q;
  logic [15:0]     shiftReg_q;
  logic [7:0]      rxReg_q;
  logic            rw_q;
  logic            busy_q;
  logic            done_q;
  logic [7:0]      rdata_q;
  logic            mosi_q;
  logic            clkSpi_q;
  logic            cs_q;

  assign divCnt_d = divCnt_q + 1'b1;
  assign divLast  = (divCnt_q == DIV_LAST);

  // miso is captured on the same edge that raises clk_spi; after 16 samples the
  // low byte of the receive history is exactly the data byte.
  always_ff @(posedge clk_system) begin
    if (reset_system) begin
      state_q    <= ST_IDLE;
      divCnt_q   <= '0;
      bitCnt_q   <= '0;
      shiftReg_q <= '0;
      rxReg_q    <= '0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= 8'h00;
      mosi_q     <= 1'b0;
      clkSpi_q   <= 1'b0;
      cs_q       <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          divCnt_q <= '0;
          if (req) begin
            rw_q       <= rw;
            shiftReg_q <= {rw, addr, 1'b0, (rw ? 8'h00 : wdata)};
            mosi_q     <= rw;
            cs_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (divLast) begin
            divCnt_q <= '0;
            bitCnt_q <= '0;
            clkSpi_q <= 1'b1;
            rxReg_q  <= {rxReg_q[6:0], miso};
            state_q  <= ST_SHIFT;
          end else begin
            divCnt_q <= divCnt_d;
          end
        end
        ST_SHIFT: begin
          if (!divLast) begin
            divCnt_q <= divCnt_d;
          end else begin
            divCnt_q <= '0;
            if (clkSpi_q) begin
              clkSpi_q   <= 1'b0;
              shiftReg_q <= {shiftReg_q[14:0], 1'b0};
              mosi_q     <= shiftReg_q[14];
            end else if (bitCnt_q == 5'd15) begin
              state_q <= ST_HOLD;
            end else begin
              bitCnt_q <= bitCnt_q + 5'd1;
              clkSpi_q <= 1'b1;
              rxReg_q  <= {rxReg_q[6:0], miso};
            end
          end
        end
        ST_HOLD: begin
          if (divLast) begin
            divCnt_q <= '0;
            cs_q     <= 1'b1;
            done_q   <= 1'b1;
            mosi_q   <= 1'b0;
            if (rw_q) begin
              rdata_q <= rxReg_q;
            end
            state_q  <= ST_DONE;
          end else begin
            divCnt_q <= divCnt_d;
          end
        end
        ST_DONE: begin
          divCnt_q <= '0;
          if (CLK_DIV == 1) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (divCnt_q == GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            divCnt_q <= divCnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign mosi    = mosi_q;
  assign clk_spi = clkSpi_q;
  assign cs      = cs_q;

endmodule
